// File: rtl/aes_keyexp_quad_nlane.sv
// AES-128/192/256 key-schedule step: next four words from an 8-word window.
// SubWord is time-shared over SBOX_LANES external S-box lanes.
module aes_keyexp_quad_nlane #(
  parameter int SBOX_LANES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              key_len,
  input  logic [5:0]              word_idx,
  input  logic [255:0]            win,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [127:0]            wq,
  output logic [8*SBOX_LANES-1:0] sbox_in,
  input  logic [8*SBOX_LANES-1:0] sbox_out
);

  localparam int L = SBOX_LANES;
  localparam int GROUPS = (L > 0) ? 4 / L : 1;
  localparam logic [1:0] LAST = 2'(GROUPS - 1);

  if (!(L == 1 || L == 2 || L == 4)) begin : g_bad_lanes
    $error("SBOX_LANES must be 1, 2 or 4");
  end

  typedef enum logic [2:0] {
    IDLE, ISSUE, CAPTURE, FINISH, ERR
  } state_t;

  typedef struct packed {
    logic       has;
    logic [1:0] pos;
    logic       rot;
    logic [3:0] ri;
  } tinfo_t;

  function automatic int nk_of(input logic [1:0] kl);
    case (kl)
      2'd0:    return 4;
      2'd1:    return 6;
      default: return 8;
    endcase
  endfunction

  function automatic logic legal_req(
    input logic [1:0] kl,
    input logic [5:0] idx
  );
    int imax;
    imax = 4 * nk_of(kl) + 24;
    return (kl != 2'd3) && (int'(idx) >= nk_of(kl))
      && (int'(idx) <= imax);
  endfunction

  // At most one transform word exists in any quartet.
  function automatic tinfo_t get_tinfo(
    input logic [1:0] kl,
    input logic [5:0] idx
  );
    tinfo_t t;
    logic [6:0] j;
    logic [6:0] q;
    logic [6:0] r;
    t = '0;
    for (int m = 0; m < 4; m++) begin
      j = {1'b0, idx} + 7'(m);
      case (kl)
        2'd0: begin
          q = j >> 2;
          r = j & 7'd3;
        end
        2'd1: begin
          q = j / 7'd6;
          r = j % 7'd6;
        end
        default: begin
          q = j >> 3;
          r = j & 7'd7;
        end
      endcase
      if (r == 7'd0) begin
        t.has = 1'b1;
        t.pos = 2'(m);
        t.rot = 1'b1;
        t.ri  = 4'(q - 7'd1);
      end else if (kl == 2'd2 && r == 7'd4) begin
        t.has = 1'b1;
        t.pos = 2'(m);
        t.rot = 1'b0;
        t.ri  = 4'd0;
      end
    end
    return t;
  endfunction

  function automatic logic has_xf(
    input logic [1:0] kl,
    input logic [5:0] idx
  );
    tinfo_t t;
    t = get_tinfo(kl, idx);
    return t.has;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t state_q, state_d;
  logic [1:0]   kl_q;
  logic [5:0]   idx_q;
  logic [255:0] win_q;
  logic [31:0]  sw_q;
  logic [1:0]   g_q;
  tinfo_t       ti_q;
  logic         accept;
  int           nk;
  logic [31:0]  pre [4];
  logic [31:0]  outw [4];
  logic [31:0]  ppre, pout, back, tmp, src, srcr;
  logic [8*L-1:0] sbox_nx;
  logic [8*L-1:0] grp;

  assign ti_q   = get_tinfo(kl_q, idx_q);
  assign accept = (state_q == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (!legal_req(key_len, word_idx))
            state_d = ERR;
          else if (has_xf(key_len, word_idx))
            state_d = ISSUE;
          else
            state_d = FINISH;
        end
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = (g_q == LAST) ? FINISH : ISSUE;
      FINISH:  state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // pre[] is the plain chain; it equals the real words ahead of the
  // transform word, which is all the SubWord source ever needs.
  always_comb begin
    nk   = nk_of(kl_q);
    ppre = win_q[31:0];
    pout = win_q[31:0];
    back = '0;
    tmp  = '0;
    for (int m = 0; m < 4; m++) begin
      back    = win_q[32*(nk-1-m) +: 32];
      pre[m]  = back ^ ppre;
      ppre    = pre[m];
      tmp     = pout;
      if (ti_q.has && ti_q.pos == 2'(m))
        tmp = sw_q ^ (ti_q.rot ? {rcon(ti_q.ri), 24'h0} : 32'h0);
      outw[m] = back ^ tmp;
      pout    = outw[m];
    end
    src  = (ti_q.pos == 2'd0) ? win_q[31:0] : pre[ti_q.pos - 2'd1];
    srcr = ti_q.rot ? {src[23:0], src[31:24]} : src;
    sbox_nx = '0;
    grp     = '0;
    for (int l = 0; l < L; l++) begin
      sbox_nx[8*l +: 8] = srcr[8*(3 - (int'(g_q)*L + l)) +: 8];
      grp[8*(L-1-l) +: 8] = sbox_out[8*l +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      wq      <= '0;
      sbox_in <= '0;
      kl_q    <= '0;
      idx_q   <= '0;
      win_q   <= '0;
      sw_q    <= '0;
      g_q     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (accept) begin
        kl_q  <= key_len;
        idx_q <= word_idx;
        win_q <= win;
        sw_q  <= '0;
        g_q   <= '0;
        busy  <= 1'b1;
      end
      if (state_q == ISSUE)
        sbox_in <= sbox_nx;
      if (state_q == CAPTURE) begin
        sw_q <= (sw_q << (8*L)) | 32'(grp);
        g_q  <= g_q + 2'd1;
      end
      if (state_q == FINISH) begin
        wq   <= {outw[0], outw[1], outw[2], outw[3]};
        done <= 1'b1;
        busy <= 1'b0;
      end
      if (state_q == ERR) begin
        done <= 1'b1;
        err  <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule
